// File: rtl/cla_pipe_adder_pkg.sv
// Shared constants for the pipelined carry-look-ahead adder.
package cla_pipe_adder_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned LA_BITS   = 4;
  localparam int unsigned NGROUPS   = DEF_WIDTH / LA_BITS;
  localparam int unsigned NSTAGES   = 3;

endpackage

// File: rtl/cla_pipe_adder_pg.sv
// Stage-1 operand conditioning: subtract mux plus bitwise generate/propagate.
// Ports: a/b operands, cin carry-in (ignored on sub), sub select,
//        g_c/p_c bitwise generate/propagate, c0_c effective carry-in.
module cla_pg_gen #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] g_c,
  output logic [WIDTH-1:0] p_c,
  output logic             c0_c
);

  logic [WIDTH-1:0] beff;

  // Two's-complement subtract: invert B and force the carry-in.
  always_comb begin
    beff = sub ? ~b : b;
    c0_c = sub ? 1'b1 : cin;
    g_c  = a & beff;
    p_c  = a ^ beff;
  end

endmodule

// File: rtl/look_ahead.sv
// 4-bit carry-look-ahead cell.
// Ports: g/p  bitwise generate/propagate, cin  group carry-in,
//        carry_c  carry into each of the 4 bits (carry_c[0] = cin),
//        grp_g_c/grp_p_c  group generate/propagate.
module look_ahead (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] carry_c,
  output logic       grp_g_c,
  output logic       grp_p_c
);

  // Flattened two-level carry terms, no ripple.
  always_comb begin
    carry_c[0] = cin;
    carry_c[1] = g[0] | (p[0] & cin);
    carry_c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    carry_c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
               | (p[2] & p[1] & p[0] & cin);
    grp_g_c    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
               | (p[3] & p[2] & p[1] & g[0]);
    grp_p_c    = &p;
  end

endmodule

// File: rtl/cla_pipe_adder.sv
// Three-stage pipelined carry-look-ahead adder/subtractor with valid/ready
// on both sides.
// Ports: clk, rst (sync, active-high); in_valid/in_ready, a, b, cin, sub on
//        the input side; out_valid/out_ready, sum, cout, ovf on the output.
module cla_pipe_adder
  import cla_pipe_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned N_GRP = WIDTH / LA_BITS;

  logic en1, en2, en3;

  logic             v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [WIDTH-1:0] g1_q, g1_d, p1_q, p1_d;
  logic             c0_q, c0_d;
  logic [WIDTH-1:0] g2_q, g2_d, p2_q, p2_d;
  logic [N_GRP:0]   c2_q, c2_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, ovf_q, ovf_d;

  logic [WIDTH-1:0] pg_g, pg_p;
  logic             pg_c0;
  logic [N_GRP-1:0] grp_g, grp_p;
  logic [N_GRP:0]   chain_c;
  logic [WIDTH-1:0] bit_c;
  logic [WIDTH-1:0] s2_carry_unused;
  logic [N_GRP-1:0] s3_gg_unused, s3_gp_unused;

  // A stage may load when it is empty or the stage after it is moving.
  assign en3      = !v3_q | out_ready;
  assign en2      = !v2_q | en3;
  assign en1      = !v1_q | en2;
  assign in_ready = en1;

  cla_pg_gen #(.WIDTH(WIDTH)) u_pg (
    .a    (a),
    .b    (b),
    .cin  (cin),
    .sub  (sub),
    .g_c  (pg_g),
    .p_c  (pg_p),
    .c0_c (pg_c0)
  );

  // Stage 2: group generate/propagate per nibble.
  for (genvar k = 0; k < N_GRP; k++) begin : g_s2
    look_ahead u_grp (
      .g       (g1_q[k*LA_BITS +: LA_BITS]),
      .p       (p1_q[k*LA_BITS +: LA_BITS]),
      .cin     (1'b0),
      .carry_c (s2_carry_unused[k*LA_BITS +: LA_BITS]),
      .grp_g_c (grp_g[k]),
      .grp_p_c (grp_p[k])
    );
  end

  // Group carry chain across nibbles.
  always_comb begin
    chain_c    = '0;
    chain_c[0] = c0_q;
    for (int k = 0; k < N_GRP; k++) begin
      chain_c[k+1] = grp_g[k] | (grp_p[k] & chain_c[k]);
    end
  end

  // Stage 3: per-bit carries inside each nibble from its group carry-in.
  for (genvar k = 0; k < N_GRP; k++) begin : g_s3
    look_ahead u_bit (
      .g       (g2_q[k*LA_BITS +: LA_BITS]),
      .p       (p2_q[k*LA_BITS +: LA_BITS]),
      .cin     (c2_q[k]),
      .carry_c (bit_c[k*LA_BITS +: LA_BITS]),
      .grp_g_c (s3_gg_unused[k]),
      .grp_p_c (s3_gp_unused[k])
    );
  end

  // Next-state: each stage holds unless its enable is set.
  always_comb begin
    v1_d   = v1_q;
    g1_d   = g1_q;
    p1_d   = p1_q;
    c0_d   = c0_q;
    v2_d   = v2_q;
    g2_d   = g2_q;
    p2_d   = p2_q;
    c2_d   = c2_q;
    v3_d   = v3_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    if (en1) begin
      v1_d = in_valid;
      g1_d = pg_g;
      p1_d = pg_p;
      c0_d = pg_c0;
    end
    if (en2) begin
      v2_d = v1_q;
      g2_d = g1_q;
      p2_d = p1_q;
      c2_d = chain_c;
    end
    if (en3) begin
      v3_d   = v2_q;
      sum_d  = p2_q ^ bit_c;
      cout_d = c2_q[N_GRP];
      ovf_d  = bit_c[WIDTH-1] ^ c2_q[N_GRP];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      g1_q   <= '0;
      p1_q   <= '0;
      c0_q   <= 1'b0;
      v2_q   <= 1'b0;
      g2_q   <= '0;
      p2_q   <= '0;
      c2_q   <= '0;
      v3_q   <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      g1_q   <= g1_d;
      p1_q   <= p1_d;
      c0_q   <= c0_d;
      v2_q   <= v2_d;
      g2_q   <= g2_d;
      p2_q   <= p2_d;
      c2_q   <= c2_d;
      v3_q   <= v3_d;
      sum_q  <= sum_d;
      cout_q <= cout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = v3_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboarded bench for cla_pipe_adder: driver pushes expected results on
// acceptance, an independent monitor pops and compares on each output beat.
module tb_cla_pipe_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        cin, sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum;
  logic        cout, ovf;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  cla_pipe_adder #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  // Reference: plain 33-bit arithmetic plus the sign rule for overflow.
  function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                 input logic mcin, input logic msub);
    exp_t        r;
    logic [31:0] be;
    logic [32:0] full;
    be     = msub ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, be} + 33'(msub ? 1'b1 : mcin);
    r.sum  = full[31:0];
    r.cout = full[32];
    r.ovf  = (ma[31] == be[31]) && (r.sum[31] != ma[31]);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Drive one cycle; inputs change at negedge, handshake sampled just before posedge.
  task automatic step(input logic v, input logic [31:0] ta, input logic [31:0] tb,
                      input logic tcin, input logic tsub, input logic tordy,
                      output logic acc);
    @(negedge clk);
    in_valid  = v;
    a         = ta;
    b         = tb;
    cin       = tcin;
    sub       = tsub;
    out_ready = tordy;
    #4;
    acc = in_valid & in_ready;
    if (acc) sb_q.push_back(model(ta, tb, tcin, tsub));
  endtask

  task automatic idle(input logic tordy);
    logic acc;
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, tordy, acc);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb_q.size() != 0 || out_valid) && n < 50) begin
      idle(1'b1);
      n++;
    end
    check("drain_timeout", 64'(n >= 50), 64'd0);
  endtask

  // Monitor: every transferred output beat must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 64'(out_valid), 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", 64'({sum, cout, ovf}), 64'(e));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    logic acc;
    int   lat;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #4;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout_ovf", 64'({cout, ovf}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // Directed arithmetic corners.
    step(1'b1, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, acc);
    step(1'b1, 32'd5,         32'd7,         1'b0, 1'b1, 1'b1, acc);
    step(1'b1, 32'd5,         32'd7,         1'b1, 1'b1, 1'b1, acc);
    step(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, acc);
    step(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 1'b1, acc);
    drain();

    // Backpressure: pipeline holds three beats, fourth and fifth stall.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'(i), 32'(i), 1'b0, 1'b0, 1'b0, acc);
      check("bp_accept", 64'(acc), 64'(i < 3));
    end
    for (int i = 3; i < 5; i++) begin
      int n = 0;
      acc = 1'b0;
      while (!acc && n < 10) begin
        step(1'b1, 32'(i), 32'(i), 1'b0, 1'b0, 1'b1, acc);
        n++;
      end
      check("bp_late_accept", 64'(acc), 64'd1);
    end
    drain();

    // Alternating bubbles with random backpressure.
    for (int i = 0; i < 200; i++) begin
      step(1'(i % 2 == 0), $urandom, $urandom, 1'($urandom), 1'($urandom),
           1'($urandom), acc);
    end
    drain();

    // Random valid density and backpressure.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) != 0), acc);
    end
    drain();

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 32'(100 + i), 32'd1, 1'b0, 1'b0, 1'b0, acc);
    end
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #4;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 1'b1, acc);
    check("post_rst_accept", 64'(acc), 64'd1);
    lat = 0;
    for (int n = 1; n <= 10; n++) begin
      idle(1'b1);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    check("latency", 64'(lat), 64'd3);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Three-stage pipelined carry-look-ahead adder/subtractor for the datapath ALU.
- Stage 1 produces the bitwise generate/propagate terms that feed the existing 4-bit look_ahead cells; stage 2 resolves group carries; stage 3 forms sum and flags.
- Valid/ready handshake on both sides, so the block tolerates backpressure from the consuming stage.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of 4 (4-bit groups).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  1 = A-B (B inverted, carry-in forced 1).
- out_valid  output  1  result beat present.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for sub: 1 = no borrow).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (clk edge with rst=1): v1, v2, v3 = 0; out_valid = 0; sum, cout and ovf = 0; all stage data registers = 0. rst overrides any in-flight beats, which are discarded.
- Advance enables:
  - en3 = !v3 | out_ready.
  - en2 = !v2 | en3.
  - en1 = !v1 | en2.
  - in_ready = en1 (combinational; no path from in_valid to in_ready).
- S1, on en1:
  - v1 <= in_valid.
  - If in_valid: beff = sub ? ~b : b; c0 = sub ? 1 : cin.
  - Register g = a & beff, p = a ^ beff, c0.
- S2, on en2:
  - v2 <= v1.
  - Per group k (bits 4k..4k+3), compute group Gk/Pk with a look_ahead cell.
  - Group carry-in chain: C[0] = c0; C[k+1] = Gk | (Pk & C[k]).
  - Register g, p, C[0..WIDTH/4].
- S3, on en3:
  - v3 <= v2.
  - Within each group, bit carries come from a look_ahead cell with cin = C[k].
  - sum = p ^ carry-in of each bit.
  - cout = C[WIDTH/4].
  - ovf = carry into bit WIDTH-1 XOR cout.
  - out_valid = v3; outputs are registered directly.
- Stall rule: a stage whose enable is 0 holds its data and valid unchanged.
- Latency: 3 cycles from acceptance to out_valid with no stall. Throughput is 1 beat/cycle while out_ready=1.
- Full pipeline with out_ready=0: in_ready=0; no beat is lost or duplicated.
- Bubbles: a bubble (v=0) entering a stage still clocks data, but data must not be observed while the valid bit is 0. A bubble in S3 lets S2 advance even when out_ready=0.
- Simultaneous accept and drain in the same cycle is legal.
- Arithmetic is modulo 2^WIDTH; there is no saturation.

Decomposition:
- Shared package/header: WIDTH default, NGROUPS = WIDTH/4, localparam for stage count (3).
- Reuse the existing 4-bit look_ahead cell: NGROUPS instances in S2 for group G/P, NGROUPS instances in S3 for bit carries.
- One natural sub-module: cla_pg_gen, the S1 combinational beff/g/p/c0 generation with the sub mux.

Test Plan:
- Add, no stall: a=0x0000_0001, b=0xFFFF_FFFF, cin=0, sub=0, out_ready=1 -> 3 cycles later sum=0x0000_0000, cout=1, ovf=0.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001 -> sum=0x8000_0000, cout=0, ovf=1. Also check sub: a=5, b=7 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
- Full-carry propagate: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. Checks that the group carry chain crosses all 8 groups.
- Backpressure: stream 5 beats (a=i, b=i) with out_ready=0.
  - in_ready drops after 3 accepts.
  - Raise out_ready: outputs 0, 2, 4, 6, 8 in order, none dropped or duplicated.
- Bubbles: alternate in_valid 1/0 with out_ready toggling pseudo-randomly -> outputs match the reference model a+b+cin in order. out_valid is never asserted for a bubble.
- Reset mid-operation: 3 beats in flight, assert rst for 1 cycle -> next cycle out_valid=0, sum=0, in_ready=1. The next accepted beat appears after exactly 3 cycles.
